int_sched: RTL and testbench

- Interrupt scheduler for the LA32 pipeline.
- Owns the constant timer (TVAL countdown, TI pending bit) and samples the hardware interrupt lines.
- Merges these with the software-interrupt bits and the EX-stage forwarded soft-interrupt flag (ex_soft_int_gen).
- Sequences a single interrupt request to the EX stage through a req/ack handshake, then masks itself until the pipeline has cleared CRMD.IE.

---
 rtl/int_sched_pkg.sv | 40 ++++
 rtl/int_sched_timer.sv | 65 ++++++
 rtl/int_sched.sv | 114 +++++++++++
 tb/tb_int_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_sched_pkg.sv
// Shared ESTAT.IS bit map, TCFG field positions and scheduler FSM encoding.
// Pure definitions: no logic, no latency, no flow control.
package int_sched_pkg;

    localparam int IS_W       = 13;
    localparam int IS_SWI_LO  = 0;
    localparam int IS_SWI_HI  = 1;
    localparam int IS_HWI_LO  = 2;
    localparam int IS_HWI_HI  = 9;
    localparam int IS_RSVD    = 10;
    localparam int IS_TI      = 11;
    localparam int IS_IPI     = 12;

    localparam int TCFG_EN         = 0;
    localparam int TCFG_PERIODIC   = 1;
    localparam int TCFG_INITVAL_LO = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_MASK = 2'd2
    } sched_state_e;

    // IS[10] has no source and always reads as zero.
    function automatic logic [IS_W-1:0] pend_vec(
        input logic [1:0] swi,
        input logic [7:0] hwi,
        input logic       ti,
        input logic       ipi
    );
        logic [IS_W-1:0] v;
        v = '0;
        v[IS_SWI_HI:IS_SWI_LO] = swi;
        v[IS_HWI_HI:IS_HWI_LO] = hwi;
        v[IS_TI]               = ti;
        v[IS_IPI]              = ipi;
        return v;
    endfunction

endpackage

// File: rtl/int_sched_timer.sv
// Constant timer: TCFG latch, TVAL countdown and TI pending flag; all updates take effect one edge after the write.
// No backpressure: CSR write commits are always accepted.
module int_timer
    import int_sched_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               tcfg_we_i,
    input  logic [TIMER_W-1:0] tcfg_wdata_i,
    input  logic               ticlr_we_i,
    input  logic               ticlr_wdata_i,
    output logic [TIMER_W-1:0] tval_o,
    output logic               ti_pending_o
);

    logic               en_q, en_d;
    logic               periodic_q, periodic_d;
    logic [TIMER_W-3:0] initval_q, initval_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic               ti_q, ti_d;
    logic               ti_fire;

    always_comb begin
        en_d       = en_q;
        periodic_d = periodic_q;
        initval_d  = initval_q;
        tval_d     = tval_q;
        ti_fire    = 1'b0;
        if (tcfg_we_i) begin
            en_d       = tcfg_wdata_i[TCFG_EN];
            periodic_d = tcfg_wdata_i[TCFG_PERIODIC];
            initval_d  = tcfg_wdata_i[TIMER_W-1:TCFG_INITVAL_LO];
            tval_d     = {tcfg_wdata_i[TIMER_W-1:TCFG_INITVAL_LO], 2'b00};
        end else if (en_q && tval_q == TIMER_W'(1)) begin
            ti_fire = 1'b1;
            tval_d  = periodic_q ? {initval_q, 2'b00} : '0;
        end else if (en_q && tval_q != '0) begin
            tval_d = tval_q - TIMER_W'(1);
        end
        // A timer expiry on the same edge as a TICLR write keeps the flag set.
        ti_d = ti_fire | (ti_q & ~(ticlr_we_i & ticlr_wdata_i));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            initval_q  <= '0;
            tval_q     <= '0;
            ti_q       <= 1'b0;
        end else begin
            en_q       <= en_d;
            periodic_q <= periodic_d;
            initval_q  <= initval_d;
            tval_q     <= tval_d;
            ti_q       <= ti_d;
        end
    end

    assign tval_o       = tval_q;
    assign ti_pending_o = ti_q;

endmodule

// File: rtl/int_sched.sv
// Interrupt scheduler: HWI sync chain, pending merge and a req/ack FSM toward EX; int_req is a registered output.
// Backpressure: one request outstanding; after ack the block stays masked until CRMD.IE is seen low.
module int_sched
    import int_sched_pkg::*;
#(
    parameter int TIMER_W     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [7:0]         hw_int_in,
    input  logic               ipi_int_in,
    input  logic [1:0]         csr_estat_swi,
    input  logic [12:0]        csr_ecfg_lie,
    input  logic               csr_crmd_ie,
    input  logic               ex_soft_int_gen,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_wdata,
    input  logic               ticlr_we,
    input  logic               ticlr_wdata,
    input  logic               flush_in,
    input  logic               int_ack,
    output logic               int_req,
    output logic [10:0]        estat_is_hw,
    output logic [TIMER_W-1:0] tval,
    output logic               ti_pending
);

    logic [SYNC_STAGES-1:0][7:0] hw_sync_q;
    logic                        ipi_q;
    sched_state_e                state_q;
    logic                        int_req_q;
    logic [IS_W-1:0]             pend;
    logic [IS_W-1:0]             lie_eff;
    logic                        take;

    int_timer #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .tcfg_we_i    (tcfg_we),
        .tcfg_wdata_i (tcfg_wdata),
        .ticlr_we_i   (ticlr_we),
        .ticlr_wdata_i(ticlr_wdata),
        .tval_o       (tval),
        .ti_pending_o (ti_pending)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hw_sync_q <= '0;
            ipi_q     <= 1'b0;
        end else begin
            hw_sync_q[0] <= hw_int_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                hw_sync_q[i] <= hw_sync_q[i-1];
            end
            ipi_q <= ipi_int_in;
        end
    end

    always_comb begin
        lie_eff          = csr_ecfg_lie;
        lie_eff[IS_RSVD] = 1'b0;
        pend = pend_vec(csr_estat_swi, hw_sync_q[SYNC_STAGES-1], ti_pending, ipi_q);
        take = csr_crmd_ie && ((|(pend & lie_eff)) || ex_soft_int_gen);
    end

    assign estat_is_hw = pend[IS_IPI:IS_HWI_LO];

    // An ack only counts while the request is actually visible to EX.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take && !flush_in) begin
                        state_q   <= ST_REQ;
                        int_req_q <= 1'b1;
                    end else begin
                        int_req_q <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (int_ack && int_req_q) begin
                        state_q   <= ST_MASK;
                        int_req_q <= 1'b0;
                    end else if (!take) begin
                        state_q   <= ST_IDLE;
                        int_req_q <= 1'b0;
                    end else begin
                        int_req_q <= !flush_in;
                    end
                end
                ST_MASK: begin
                    int_req_q <= 1'b0;
                    if (!csr_crmd_ie) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    int_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign int_req = int_req_q;

endmodule

// File: tb/tb_int_sched.sv
module tb_int_sched;

    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic [7:0]    hw_int_in;
    logic          ipi_int_in;
    logic [1:0]    csr_estat_swi;
    logic [12:0]   csr_ecfg_lie;
    logic          csr_crmd_ie;
    logic          ex_soft_int_gen;
    logic          tcfg_we;
    logic [TW-1:0] tcfg_wdata;
    logic          ticlr_we;
    logic          ticlr_wdata;
    logic          flush_in;
    logic          int_ack;
    logic          int_req;
    logic [10:0]   estat_is_hw;
    logic [TW-1:0] tval;
    logic          ti_pending;

    int total = 0;
    int bad   = 0;

    logic [TW-1:0] exp_tval_q[$];
    logic          exp_ti_q[$];
    logic          exp_req_q[$];
    logic [10:0]   exp_is_q[$];

    always #5 clk = ~clk;

    int_sched #(.TIMER_W(TW), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .csr_estat_swi(csr_estat_swi), .csr_ecfg_lie(csr_ecfg_lie), .csr_crmd_ie(csr_crmd_ie),
        .ex_soft_int_gen(ex_soft_int_gen), .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
        .ticlr_we(ticlr_we), .ticlr_wdata(ticlr_wdata), .flush_in(flush_in), .int_ack(int_ack),
        .int_req(int_req), .estat_is_hw(estat_is_hw), .tval(tval), .ti_pending(ti_pending)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic eb; logic [TW-1:0] et; logic [10:0] ei;
        resetn = 1'b0;
        exp_req_q.push_back(1'b0); exp_tval_q.push_back('0);
        exp_ti_q.push_back(1'b0);  exp_is_q.push_back('0);
        tick(); tick();
        eb = exp_req_q.pop_front();
        total++; if (int_req !== eb) begin bad++; $display("FAIL reset_req: got %0b want %0b", int_req, eb); end
        et = exp_tval_q.pop_front();
        total++; if (tval !== et) begin bad++; $display("FAIL reset_tval: got %0d want %0d", tval, et); end
        eb = exp_ti_q.pop_front();
        total++; if (ti_pending !== eb) begin bad++; $display("FAIL reset_ti: got %0b want %0b", ti_pending, eb); end
        ei = exp_is_q.pop_front();
        total++; if (estat_is_hw !== ei) begin bad++; $display("FAIL reset_is: got %h want %h", estat_is_hw, ei); end
        resetn = 1'b1;
    endtask

    // Reference countdown model driven from the TCFG word written.
    task automatic test_timer(input logic [TW-1:0] wdata, input int ncyc, input string nm);
        logic [TW-1:0] m_tval, init4, ot; logic m_ti, ob;
        init4 = {wdata[TW-1:2], 2'b00};
        m_tval = init4; m_ti = 1'b0;
        tcfg_wdata = wdata; tcfg_we = 1'b1;
        exp_tval_q.push_back(m_tval); exp_ti_q.push_back(m_ti);
        tick();
        tcfg_we = 1'b0;
        for (int i = 0; i <= ncyc; i++) begin
            ot = exp_tval_q.pop_front(); ob = exp_ti_q.pop_front();
            total++; if (tval !== ot) begin bad++; $display("FAIL %s_tval cyc %0d: got %0d want %0d", nm, i, tval, ot); end
            total++; if (ti_pending !== ob) begin bad++; $display("FAIL %s_ti cyc %0d: got %0b want %0b", nm, i, ti_pending, ob); end
            if (i == ncyc) break;
            if (wdata[0] && m_tval == 1) begin
                m_ti = 1'b1;
                m_tval = wdata[1] ? init4 : '0;
            end else if (wdata[0] && m_tval != 0) begin
                m_tval = m_tval - 1;
            end
            exp_tval_q.push_back(m_tval); exp_ti_q.push_back(m_ti);
            tick();
        end
    endtask

    task automatic test_ti_clear();
        logic [1:0] rows [5];
        logic [TW-1:0] etv [5];
        logic eti [5];
        logic [TW-1:0] ot; logic ob;
        int n = 0;
        rows = '{2'b11, 2'b00, 2'b11, 2'b11, 2'b00};
        etv  = '{32'd2, 32'd1, 32'd8, 32'd7, 32'd6};
        eti  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        while (tval !== 32'd3 && n < 20) begin tick(); n++; end
        total++; if (tval !== 32'd3) begin bad++; $display("FAIL ticlr_align: got %0d want 3", tval); end
        for (int i = 0; i < 5; i++) begin
            {ticlr_we, ticlr_wdata} = rows[i];
            exp_tval_q.push_back(etv[i]); exp_ti_q.push_back(eti[i]);
            tick();
            ot = exp_tval_q.pop_front(); ob = exp_ti_q.pop_front();
            total++; if (tval !== ot) begin bad++; $display("FAIL ticlr_tval row %0d: got %0d want %0d", i, tval, ot); end
            total++; if (ti_pending !== ob) begin bad++; $display("FAIL ticlr_ti row %0d: got %0b want %0b", i, ti_pending, ob); end
        end
        {ticlr_we, ticlr_wdata} = 2'b00;
        tcfg_wdata = '0; tcfg_we = 1'b1;
        exp_tval_q.push_back('0);
        tick();
        tcfg_we = 1'b0;
        ot = exp_tval_q.pop_front();
        total++; if (tval !== ot) begin bad++; $display("FAIL tcfg_disable: got %0d want %0d", tval, ot); end
    endtask

    task automatic test_oneshot_clear();
        logic [1:0] rows [4];
        logic eti [4];
        logic ob;
        rows = '{2'b10, 2'b11, 2'b00, 2'b00};
        eti  = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            {ticlr_we, ticlr_wdata} = rows[i];
            exp_ti_q.push_back(eti[i]); exp_tval_q.push_back('0);
            tick();
            ob = exp_ti_q.pop_front();
            total++; if (ti_pending !== ob) begin bad++; $display("FAIL oneshot_ti row %0d: got %0b want %0b", i, ti_pending, ob); end
            total++; if (tval !== exp_tval_q.pop_front()) begin bad++; $display("FAIL oneshot_tval row %0d: got %0d want 0", i, tval); end
        end
        {ticlr_we, ticlr_wdata} = 2'b00;
    endtask

    task automatic test_hwi();
        logic [2:0] rows [12];
        logic [1:0] expv [12];
        logic eb; logic [10:0] ei;
        rows = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b110,
                 3'b110, 3'b100, 3'b110, 3'b000, 3'b000, 3'b000};
        expv = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10,
                 2'b10, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00};
        csr_ecfg_lie = 13'h0020;
        for (int i = 0; i < 12; i++) begin
            hw_int_in = {4'b0, rows[i][2], 3'b0};
            csr_crmd_ie = rows[i][1];
            int_ack = rows[i][0];
            exp_is_q.push_back({7'b0, expv[i][1], 3'b0});
            exp_req_q.push_back(expv[i][0]);
            tick();
            ei = exp_is_q.pop_front(); eb = exp_req_q.pop_front();
            total++; if (estat_is_hw !== ei) begin bad++; $display("FAIL hwi_is row %0d: got %h want %h", i, estat_is_hw, ei); end
            total++; if (int_req !== eb) begin bad++; $display("FAIL hwi_req row %0d: got %0b want %0b", i, int_req, eb); end
        end
        int_ack = 1'b0;
    endtask

    task automatic test_ipi();
        logic [1:0] rows [4];
        logic [11:0] expv [4];
        logic eb; logic [10:0] ei;
        rows = '{2'b11, 2'b11, 2'b00, 2'b00};
        expv = '{{11'h400, 1'b0}, {11'h400, 1'b1}, {11'h000, 1'b0}, {11'h000, 1'b0}};
        csr_ecfg_lie = 13'h1000;
        for (int i = 0; i < 4; i++) begin
            {ipi_int_in, csr_crmd_ie} = rows[i];
            exp_is_q.push_back(expv[i][11:1]); exp_req_q.push_back(expv[i][0]);
            tick();
            ei = exp_is_q.pop_front(); eb = exp_req_q.pop_front();
            total++; if (estat_is_hw !== ei) begin bad++; $display("FAIL ipi_is row %0d: got %h want %h", i, estat_is_hw, ei); end
            total++; if (int_req !== eb) begin bad++; $display("FAIL ipi_req row %0d: got %0b want %0b", i, int_req, eb); end
        end
        csr_ecfg_lie = '0;
    endtask

    task automatic test_soft();
        logic [2:0] rows [10];
        logic ereq [10];
        logic eb;
        rows = '{3'b110, 3'b110, 3'b010, 3'b010, 3'b110,
                 3'b011, 3'b110, 3'b100, 3'b110, 3'b000};
        ereq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        csr_ecfg_lie = '0;
        for (int i = 0; i < 10; i++) begin
            {ex_soft_int_gen, csr_crmd_ie, int_ack} = rows[i];
            exp_req_q.push_back(ereq[i]);
            tick();
            eb = exp_req_q.pop_front();
            total++; if (int_req !== eb) begin bad++; $display("FAIL soft_req row %0d: got %0b want %0b", i, int_req, eb); end
        end
        int_ack = 1'b0;
    endtask

    task automatic test_flush();
        logic [3:0] rows [11];
        logic ereq [11];
        logic eb;
        rows = '{4'b1110, 4'b1100, 4'b1110, 4'b1111, 4'b1110, 4'b1100,
                 4'b1101, 4'b0100, 4'b0000, 4'b1100, 4'b0000};
        ereq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            {ex_soft_int_gen, csr_crmd_ie, flush_in, int_ack} = rows[i];
            exp_req_q.push_back(ereq[i]);
            tick();
            eb = exp_req_q.pop_front();
            total++; if (int_req !== eb) begin bad++; $display("FAIL flush_req row %0d: got %0b want %0b", i, int_req, eb); end
        end
        {flush_in, int_ack} = 2'b00;
    endtask

    task automatic test_reset_mid();
        logic eb, ob; logic [TW-1:0] et;
        tcfg_wdata = 32'h9; tcfg_we = 1'b1;
        tick();
        tcfg_we = 1'b0;
        ex_soft_int_gen = 1'b1; csr_crmd_ie = 1'b1;
        tick(); tick(); tick();
        exp_tval_q.push_back(32'd5); exp_req_q.push_back(1'b1);
        et = exp_tval_q.pop_front(); eb = exp_req_q.pop_front();
        total++; if (tval !== et) begin bad++; $display("FAIL midrst_pre_tval: got %0d want %0d", tval, et); end
        total++; if (int_req !== eb) begin bad++; $display("FAIL midrst_pre_req: got %0b want %0b", int_req, eb); end
        resetn = 1'b0;
        exp_tval_q.push_back('0); exp_req_q.push_back(1'b0); exp_ti_q.push_back(1'b0);
        tick();
        et = exp_tval_q.pop_front(); eb = exp_req_q.pop_front(); ob = exp_ti_q.pop_front();
        total++; if (tval !== et) begin bad++; $display("FAIL midrst_tval: got %0d want %0d", tval, et); end
        total++; if (int_req !== eb) begin bad++; $display("FAIL midrst_req: got %0b want %0b", int_req, eb); end
        total++; if (ti_pending !== ob) begin bad++; $display("FAIL midrst_ti: got %0b want %0b", ti_pending, ob); end
        resetn = 1'b1; ex_soft_int_gen = 1'b0; csr_crmd_ie = 1'b0;
        exp_tval_q.push_back('0);
        tick(); tick();
        et = exp_tval_q.pop_front();
        total++; if (tval !== et) begin bad++; $display("FAIL midrst_post_tval: got %0d want %0d", tval, et); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0; csr_estat_swi = '0;
        csr_ecfg_lie = '0; csr_crmd_ie = 1'b0; ex_soft_int_gen = 1'b0;
        tcfg_we = 1'b0; tcfg_wdata = '0; ticlr_we = 1'b0; ticlr_wdata = 1'b0;
        flush_in = 1'b0; int_ack = 1'b0;
        test_reset();
        test_timer(32'hB, 20, "periodic");
        test_ti_clear();
        test_timer(32'h5, 8, "oneshot");
        test_oneshot_clear();
        test_hwi();
        test_ipi();
        test_soft();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
